// File: rtl/eth_mmio_pkg.sv
// Shared definitions for the MMIO-to-AXI-Stream bridge.
// Contents: read/write register offsets (byte address bits [7:0]),
// STATUS bit positions and the layout of one TX staging FIFO entry.
package eth_mmio_pkg;

  // Read map
  localparam logic [7:0] RD_RX_DATA   = 8'h00;
  localparam logic [7:0] RD_RX_KEEP   = 8'h04;
  localparam logic [7:0] RD_RX_VALID  = 8'h08;
  localparam logic [7:0] RD_RX_LAST   = 8'h0C;
  localparam logic [7:0] RD_TX_FREE   = 8'h10;
  localparam logic [7:0] RD_STATUS    = 8'h14;
  localparam logic [7:0] RD_TS_COUNT  = 8'h18;
  localparam logic [7:0] RD_RX_TICKS  = 8'h1C;
  localparam logic [7:0] RD_TX_TICKS  = 8'h20;
  localparam logic [7:0] RD_RX_FRAMES = 8'h24;
  localparam logic [7:0] RD_TX_FRAMES = 8'h28;

  // Write map
  localparam logic [7:0] WR_TX_DATA = 8'h00;
  localparam logic [7:0] WR_TX_KEEP = 8'h04;
  localparam logic [7:0] WR_TX_LAST = 8'h08;
  localparam logic [7:0] WR_IRQ_EN  = 8'h0C;
  localparam logic [7:0] WR_STATUS  = 8'h10;
  localparam logic [7:0] WR_CLR     = 8'h14;

  // STATUS bits
  localparam int ST_RX_VALID = 0;
  localparam int ST_TS_VALID = 1;
  localparam int ST_TX_OVF   = 2;
  localparam int ST_TS_OVF   = 3;
  localparam int ST_PHY_DONE = 4;

  localparam int TX_ENTRY_W = 37;

  // One staged TX word: {last, keep, data}
  typedef struct packed {
    logic        last;
    logic [3:0]  keep;
    logic [31:0] data;
  } tx_entry_t;

endpackage

// File: rtl/eth_mmio_axis_bridge_if.sv
// AXI-Stream link between the bridge and the MAC FIFO.
// Signals: tdata[31:0], tkeep[3:0], tlast, tvalid, tready.
// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// are both high; once tvalid is raised the source holds tdata/tkeep/tlast
// stable until that transfer, and tvalid never depends on tready.
// master drives data/valid, slave drives ready.
interface eth_mmio_axis_bridge_if;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/eth_sync_fifo.sv
// Single-clock show-ahead FIFO: dout always shows the head entry.
// Ports: push/din write side, pop read side, empty/full flags, count
// of stored entries. A push into a full FIFO is accepted only when a pop
// happens in the same cycle; otherwise it is discarded. Pops on empty are
// ignored. Reset flushes the pointers; storage itself is not cleared.
module eth_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/eth_mmio_axis_bridge.sv
// CPU strobe/done bus to MAC AXI-Stream bridge.
// Ports: clk, rst_n (async active-low); strobe_i/addr_i/we_i/data_i bus
// request, done_o (2 cycles after strobe_i) and data_o (registered read
// data); tx_axis (master, to MAC) fed from a TX staging FIFO; rx_axis
// (slave, from MAC) popped by reads of RX_DATA; phy_rstdone_i shown in
// STATUS; irq_o = registered OR of enabled pending STATUS[3:0] bits.
// Also keeps a free-running tick counter, a {rx_tick, tx_tick} timestamp
// FIFO per transmitted frame, and RX/TX frame counters.
module eth_mmio_axis_bridge
  import eth_mmio_pkg::*;
#(
  parameter int TX_DEPTH  = 16,
  parameter int TS_DEPTH  = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          strobe_i,
  input  logic [31:0]                   addr_i,
  input  logic                          we_i,
  input  logic [31:0]                   data_i,
  output logic                          done_o,
  output logic [31:0]                   data_o,
  eth_mmio_axis_bridge_if.master        tx_axis,
  eth_mmio_axis_bridge_if.slave         rx_axis,
  input  logic                          phy_rstdone_i,
  output logic                          irq_o
);
  localparam int TXAW = $clog2(TX_DEPTH);
  localparam int TSAW = $clog2(TS_DEPTH);

  logic [7:0]             reg_addr;
  logic                   rd_req, wr_req;
  logic                   unused_addr;
  logic [CNT_WIDTH-1:0]   tick, rx_tmp, rx_frames, tx_frames;
  logic                   rx_first;
  logic [3:0]             tx_keep, irq_en;
  logic                   tx_last, tx_ovf, ts_ovf, strobe_d;
  tx_entry_t              tx_din, tx_head;
  logic                   tx_push, tx_pop, tx_empty, tx_full, tx_last_hs;
  logic [TXAW:0]          tx_count;
  logic [2*CNT_WIDTH-1:0] ts_din, ts_head;
  logic                   ts_push, ts_pop, ts_empty, ts_full;
  logic [TSAW:0]          ts_count;
  logic                   rx_pop, clr_frames;
  logic [4:0]             status;
  logic [31:0]            rdata;

  assign reg_addr    = addr_i[7:0];
  assign unused_addr = ^addr_i[31:8];
  assign rd_req      = strobe_i & ~we_i;
  assign wr_req      = strobe_i & we_i;

  // RX: the read strobe of RX_DATA is itself the pop.
  assign rx_pop         = rd_req & (reg_addr == RD_RX_DATA) & rx_axis.tvalid;
  assign rx_axis.tready = rx_pop;

  // TX staging FIFO head drives the stream directly.
  assign tx_push         = wr_req & (reg_addr == WR_TX_DATA);
  assign tx_din          = '{last: tx_last, keep: tx_keep, data: data_i};
  assign tx_axis.tdata   = tx_head.data;
  assign tx_axis.tkeep   = tx_head.keep;
  assign tx_axis.tlast   = tx_head.last;
  assign tx_axis.tvalid  = ~tx_empty;
  assign tx_pop          = ~tx_empty & tx_axis.tready;
  assign tx_last_hs      = tx_pop & tx_head.last;

  eth_sync_fifo #(.WIDTH(TX_ENTRY_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .din(tx_din), .pop(tx_pop),
    .dout(tx_head), .empty(tx_empty), .full(tx_full), .count(tx_count)
  );

  // Timestamp entry: upper half = tick of first RX word, lower = TX tlast tick.
  assign ts_push = tx_last_hs;
  assign ts_din  = {rx_tmp, tick};
  assign ts_pop  = rd_req & (reg_addr == RD_TX_TICKS) & ~ts_empty;

  eth_sync_fifo #(.WIDTH(2*CNT_WIDTH), .DEPTH(TS_DEPTH)) u_ts_fifo (
    .clk(clk), .rst_n(rst_n), .push(ts_push), .din(ts_din), .pop(ts_pop),
    .dout(ts_head), .empty(ts_empty), .full(ts_full), .count(ts_count)
  );

  assign clr_frames = wr_req & (reg_addr == WR_CLR) & data_i[0];
  assign status     = {phy_rstdone_i, ts_ovf, tx_ovf, ~ts_empty, rx_axis.tvalid};

  always_comb begin
    rdata = '0;
    case (reg_addr)
      RD_RX_DATA:   if (rx_axis.tvalid) rdata = rx_axis.tdata;
      RD_RX_KEEP:   rdata[3:0] = rx_axis.tkeep;
      RD_RX_VALID:  rdata[0] = rx_axis.tvalid;
      RD_RX_LAST:   rdata[0] = rx_axis.tlast;
      RD_TX_FREE:   rdata = 32'(TX_DEPTH) - 32'(tx_count);
      RD_STATUS:    rdata[4:0] = status;
      RD_TS_COUNT:  rdata = 32'(ts_count);
      RD_RX_TICKS:  if (!ts_empty) rdata[CNT_WIDTH-1:0] = ts_head[2*CNT_WIDTH-1:CNT_WIDTH];
      RD_TX_TICKS:  if (!ts_empty) rdata[CNT_WIDTH-1:0] = ts_head[CNT_WIDTH-1:0];
      RD_RX_FRAMES: rdata[CNT_WIDTH-1:0] = rx_frames;
      RD_TX_FRAMES: rdata[CNT_WIDTH-1:0] = tx_frames;
      default:      ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick      <= '0;
      rx_tmp    <= '0;
      rx_first  <= 1'b1;
      rx_frames <= '0;
      tx_frames <= '0;
      tx_keep   <= 4'hF;
      tx_last   <= 1'b0;
      tx_ovf    <= 1'b0;
      ts_ovf    <= 1'b0;
      irq_en    <= '0;
      strobe_d  <= 1'b0;
      done_o    <= 1'b0;
      data_o    <= '0;
      irq_o     <= 1'b0;
    end else begin
      tick     <= tick + CNT_WIDTH'(1);
      strobe_d <= strobe_i;
      done_o   <= strobe_d;
      if (rd_req) data_o <= rdata;

      // rx_first re-arms after a tlast pop so the next pop starts a new frame.
      if (rx_pop) begin
        if (rx_first) rx_tmp <= tick;
        rx_first <= rx_axis.tlast;
      end

      if (clr_frames) begin
        rx_frames <= '0;
        tx_frames <= '0;
      end else begin
        if (rx_pop && rx_axis.tlast) rx_frames <= rx_frames + CNT_WIDTH'(1);
        if (tx_last_hs)              tx_frames <= tx_frames + CNT_WIDTH'(1);
      end

      if (wr_req) begin
        case (reg_addr)
          WR_TX_KEEP: tx_keep <= data_i[3:0];
          WR_TX_LAST: tx_last <= data_i[0];
          WR_IRQ_EN:  irq_en  <= data_i[3:0];
          WR_STATUS: begin
            if (data_i[ST_TX_OVF]) tx_ovf <= 1'b0;
            if (data_i[ST_TS_OVF]) ts_ovf <= 1'b0;
          end
          default: ;
        endcase
      end
      if (tx_push) tx_last <= 1'b0;

      // New overflow events take priority over a same-cycle W1C.
      if (tx_push && tx_full && !tx_pop) tx_ovf <= 1'b1;
      if (ts_push && ts_full && !ts_pop) ts_ovf <= 1'b1;

      irq_o <= |(status[3:0] & irq_en);
    end
  end
endmodule

// File: tb/tb_eth_mmio_axis_bridge.sv
// Directed bench for eth_mmio_axis_bridge: CPU bus tasks, a MAC RX source
// model, a TX beat monitor and immediate-assertion checks.
module tb_eth_mmio_axis_bridge;
  import eth_mmio_pkg::*;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strobe = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        phy = 1'b0;
  logic        done;
  logic [31:0] rdata_o;
  logic        irq;

  always #5 clk = ~clk;

  eth_mmio_axis_bridge_if tx_if ();
  eth_mmio_axis_bridge_if rx_if ();

  eth_mmio_axis_bridge #(.TX_DEPTH(16), .TS_DEPTH(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .strobe_i(strobe), .addr_i(addr), .we_i(we),
    .data_i(wdata), .done_o(done), .data_o(rdata_o), .tx_axis(tx_if),
    .rx_axis(rx_if), .phy_rstdone_i(phy), .irq_o(irq)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [36:0] tx_q[$];   // observed TX beats {last, keep, data}
  logic [31:0] tl_q[$];   // tick at each observed TX tlast handshake
  logic [36:0] rx_q[$];   // MAC RX words still to present
  logic [31:0] tb_tick;   // free-running reference tick since reset release
  logic [31:0] pop_tick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_tick <= '0;
    else        tb_tick <= tb_tick + 32'd1;
  end

  // Inputs change only at posedge+1, so values seen here are those of the next edge.
  always @(negedge clk) begin
    if (rst_n && tx_if.tvalid && tx_if.tready) begin
      tx_q.push_back({tx_if.tlast, tx_if.tkeep, tx_if.tdata});
      if (tx_if.tlast) tl_q.push_back(tb_tick);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rx_load();
    if (rx_q.size() != 0) begin
      {rx_if.tlast, rx_if.tkeep, rx_if.tdata} = rx_q[0];
      rx_if.tvalid = 1'b1;
    end else begin
      {rx_if.tlast, rx_if.tkeep, rx_if.tdata} = '0;
      rx_if.tvalid = 1'b0;
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    step(); strobe = 1'b1; we = 1'b1; addr = {24'h0, a}; wdata = d;
    step(); strobe = 1'b0; we = 1'b0;
    step(); check("done_w", 64'(done), 64'(1));
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    logic pop;
    step(); strobe = 1'b1; we = 1'b0; addr = {24'h0, a};
    pop = (a == RD_RX_DATA) && rx_if.tvalid;
    if (pop) pop_tick = tb_tick;
    step(); strobe = 1'b0; d = rdata_o;
    check("done_early", 64'(done), 64'(0));
    if (pop) begin
      void'(rx_q.pop_front());
      rx_load();
    end
    step(); check("done_r", 64'(done), 64'(1));
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, 64'(d), 64'(exp));
  endtask

  function automatic logic [36:0] beat(input int i);
    if (i < tx_q.size()) return tx_q[i];
    return 'x;
  endfunction

  function automatic logic [31:0] tl_at(input int i);
    if (i < tl_q.size()) return tl_q[i];
    return 'x;
  endfunction

  initial begin
    logic [31:0] t0, rx_t, tx_t;
    tx_if.tready = 1'b0;
    rx_load();

    // reset state
    step(3);
    check("rst_tvalid", 64'(tx_if.tvalid), 64'(0));
    check("rst_irq", 64'(irq), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_data_o", 64'(rdata_o), 64'(0));
    rst_n = 1'b1;
    rd_chk("rst_tx_free", RD_TX_FREE, 32'd16);
    rd_chk("rst_status", RD_STATUS, 32'h0);
    rd_chk("rst_ts_count", RD_TS_COUNT, 32'd0);
    rd_chk("rst_rx_frames", RD_RX_FRAMES, 32'd0);
    rd_chk("rst_tx_frames", RD_TX_FRAMES, 32'd0);
    rd_chk("rst_tx_ticks_empty", RD_TX_TICKS, 32'd0);

    // T1: 3-word TX frame, tready held high
    tx_if.tready = 1'b1;
    tx_q.delete(); tl_q.delete();
    bus_write(WR_TX_KEEP, 32'hF);
    bus_write(WR_TX_DATA, 32'h1111_1111);
    bus_write(WR_TX_DATA, 32'h2222_2222);
    bus_write(WR_TX_LAST, 32'h1);
    bus_write(WR_TX_DATA, 32'h3333_3333);
    step(4);
    check("t1_beats", 64'(tx_q.size()), 64'(3));
    check("t1_beat0", 64'(beat(0)), 64'({1'b0, 4'hF, 32'h1111_1111}));
    check("t1_beat1", 64'(beat(1)), 64'({1'b0, 4'hF, 32'h2222_2222}));
    check("t1_beat2", 64'(beat(2)), 64'({1'b1, 4'hF, 32'h3333_3333}));
    rd_chk("t1_tx_frames", RD_TX_FRAMES, 32'd1);
    bus_write(WR_IRQ_EN, 32'h0);
    check("t1_data_o_hold", 64'(rdata_o), 64'(1));
    rd_chk("t1_ts_count", RD_TS_COUNT, 32'd1);
    rd_chk("t1_status", RD_STATUS, 32'h2);
    rd_chk("t1_rx_ticks", RD_RX_TICKS, 32'd0);
    rd_chk("t1_tx_ticks", RD_TX_TICKS, tl_at(0));
    rd_chk("t1_ts_drained", RD_TS_COUNT, 32'd0);

    // T2: overflow the TX FIFO with tready low
    tx_if.tready = 1'b0;
    tx_q.delete();
    bus_write(WR_TX_KEEP, 32'h3);
    for (int i = 0; i < 17; i++) bus_write(WR_TX_DATA, 32'(i));
    rd_chk("t2_tx_free", RD_TX_FREE, 32'd0);
    rd_chk("t2_status_ovf", RD_STATUS, 32'h4);
    check("t2_hold_valid", 64'(tx_if.tvalid), 64'(1));
    check("t2_hold_head", 64'({tx_if.tlast, tx_if.tkeep, tx_if.tdata}), 64'({1'b0, 4'h3, 32'h0}));
    check("t2_no_beats", 64'(tx_q.size()), 64'(0));
    bus_write(WR_STATUS, 32'h4);
    rd_chk("t2_status_w1c", RD_STATUS, 32'h0);
    tx_if.tready = 1'b1;
    step(20);
    check("t2_beats", 64'(tx_q.size()), 64'(16));
    check("t2_first", 64'(beat(0)), 64'({1'b0, 4'h3, 32'd0}));
    check("t2_last", 64'(beat(15)), 64'({1'b0, 4'h3, 32'd15}));
    rd_chk("t2_tx_frames", RD_TX_FRAMES, 32'd1);

    // T3: 2-word RX frame
    rx_q.push_back({1'b0, 4'hF, 32'hA5A5_A5A5});
    rx_q.push_back({1'b1, 4'h3, 32'h0000_BEEF});
    rx_load();
    rd_chk("t3_rx_valid", RD_RX_VALID, 32'h1);
    rd_chk("t3_rx_keep0", RD_RX_KEEP, 32'hF);
    rd_chk("t3_status", RD_STATUS, 32'h1);
    rd_chk("t3_data0", RD_RX_DATA, 32'hA5A5_A5A5);
    t0 = pop_tick;
    rd_chk("t3_rx_last", RD_RX_LAST, 32'h1);
    rd_chk("t3_rx_keep1", RD_RX_KEEP, 32'h3);
    rd_chk("t3_data1", RD_RX_DATA, 32'h0000_BEEF);
    rd_chk("t3_rx_frames", RD_RX_FRAMES, 32'd1);
    rd_chk("t3_rx_valid0", RD_RX_VALID, 32'h0);
    rd_chk("t3_data_empty", RD_RX_DATA, 32'h0);
    rd_chk("t3_rx_frames_nopop", RD_RX_FRAMES, 32'd1);

    // T4: echo frame and timestamp pair, then TS overflow
    tx_q.delete(); tl_q.delete();
    bus_write(WR_TX_LAST, 32'h1);
    bus_write(WR_TX_DATA, 32'hCAFE_0001);
    step(3);
    check("t4_echo_beat", 64'(beat(0)), 64'({1'b1, 4'h3, 32'hCAFE_0001}));
    rd_chk("t4_ts_count", RD_TS_COUNT, 32'd1);
    bus_read(RD_RX_TICKS, rx_t);
    check("t4_rx_ticks", 64'(rx_t), 64'(t0));
    bus_read(RD_TX_TICKS, tx_t);
    check("t4_tx_ticks", 64'(tx_t), 64'(tl_at(0)));
    check("t4_latency", 64'(tx_t - rx_t), 64'(tl_at(0) - t0));
    tl_q.delete();
    for (int k = 0; k < 5; k++) begin
      bus_write(WR_TX_LAST, 32'h1);
      bus_write(WR_TX_DATA, 32'h100 + 32'(k));
    end
    step(3);
    check("t4_frames_sent", 64'(tl_q.size()), 64'(5));
    rd_chk("t4_ts_full", RD_TS_COUNT, 32'd4);
    rd_chk("t4_status_ovf", RD_STATUS, 32'hA);
    for (int k = 0; k < 4; k++) rd_chk("t4_ts_oldest", RD_TX_TICKS, tl_at(k));
    rd_chk("t4_ts_empty_read", RD_TX_TICKS, 32'd0);
    rd_chk("t4_ts_count0", RD_TS_COUNT, 32'd0);
    bus_write(WR_STATUS, 32'h8);
    rd_chk("t4_status_w1c", RD_STATUS, 32'h0);
    rd_chk("t4_tx_frames", RD_TX_FRAMES, 32'd7);
    bus_write(WR_CLR, 32'h1);
    rd_chk("t4_tx_frames_clr", RD_TX_FRAMES, 32'd0);
    rd_chk("t4_rx_frames_clr", RD_RX_FRAMES, 32'd0);

    // T5: IRQ on rx_valid, then masked
    bus_write(WR_IRQ_EN, 32'h1);
    rx_q.push_back({1'b1, 4'hF, 32'h1234_5678});
    rx_load();
    step(2);
    check("t5_irq_set", 64'(irq), 64'(1));
    rd_chk("t5_rx_data", RD_RX_DATA, 32'h1234_5678);
    step(1);
    check("t5_irq_clear", 64'(irq), 64'(0));
    bus_write(WR_IRQ_EN, 32'h0);
    rx_q.push_back({1'b1, 4'hF, 32'h9ABC_DEF0});
    rx_load();
    step(3);
    check("t5_irq_masked", 64'(irq), 64'(0));
    rd_chk("t5_rx_data2", RD_RX_DATA, 32'h9ABC_DEF0);
    rd_chk("t5_rx_frames", RD_RX_FRAMES, 32'd2);

    // T6: reset in the middle of a TX frame
    phy = 1'b1;
    rd_chk("t6_status_phy", RD_STATUS, 32'h10);
    tx_if.tready = 1'b0;
    tx_q.delete();
    bus_write(WR_TX_KEEP, 32'h5);
    bus_write(WR_TX_DATA, 32'hDEAD_0001);
    bus_write(WR_TX_DATA, 32'hDEAD_0002);
    check("t6_pre_valid", 64'(tx_if.tvalid), 64'(1));
    step();
    rst_n = 1'b0;
    #1;
    check("t6_tvalid_async", 64'(tx_if.tvalid), 64'(0));
    check("t6_irq", 64'(irq), 64'(0));
    step(2);
    rst_n = 1'b1;
    check("t6_data_o", 64'(rdata_o), 64'(0));
    check("t6_done", 64'(done), 64'(0));
    rd_chk("t6_tx_free", RD_TX_FREE, 32'd16);
    rd_chk("t6_status", RD_STATUS, 32'h10);
    rd_chk("t6_ts_count", RD_TS_COUNT, 32'd0);
    rd_chk("t6_tx_frames", RD_TX_FRAMES, 32'd0);
    rd_chk("t6_rx_frames", RD_RX_FRAMES, 32'd0);
    rd_chk("t6_rx_ticks", RD_RX_TICKS, 32'd0);
    tx_if.tready = 1'b1;
    step(5);
    check("t6_no_stale_beats", 64'(tx_q.size()), 64'(0));
    bus_write(WR_TX_DATA, 32'h55AA_55AA);
    step(3);
    check("t6_keep_last_reset", 64'(beat(0)), 64'({1'b0, 4'hF, 32'h55AA_55AA}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
